ws2812_frame_ctrl: RTL and testbench
====================================

WS2812_FRAME_CTRL -- requirements
Module: ws2812_frame_ctrl

Interface
REQ-001 SHALL have parameter: LATCH_CYCLES, 4000, length of the latch (reset) low interval in i_clk cycles, minimum 2.
REQ-002 SHALL have parameter: NPIX_W, 10, width of the pixel-count input.
REQ-003 SHALL have port: i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port: i_reset_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port: i_start  in  1  frame start request.
REQ-006 SHALL have port: i_num_pixels  in  NPIX_W  pixels in the frame; sampled only when a start is accepted.
REQ-007 SHALL have port: i_pixel_data  in  24  pixel word, MSB sent first.
REQ-008 SHALL have port: i_pixel_valid  in  1  pixel word valid.
REQ-009 SHALL have port: o_pixel_ready  out  1  pixel word accepted when valid and ready are both high.
REQ-010 SHALL have port: o_bit  out  1  bit value to the bit encoder.
REQ-011 SHALL have port: o_bit_valid  out  1  bit value valid.
REQ-012 SHALL have port: i_bit_ready  in  1  encoder accepts the bit when valid and ready are both high.
REQ-013 SHALL have port: o_latch  out  1  high during the latch interval; the encoder holds the line low.
REQ-014 SHALL have port: o_busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port: o_frame_done  out  1  one-cycle pulse at the end of the latch interval.
REQ-016 SHALL have port: o_underrun  out  1  high in each cycle a mid-frame pixel fetch stalls.

Function
REQ-017 SHALL implement the states IDLE, FETCH, SHIFT and LATCH.
REQ-018 In IDLE, i_start high SHALL load the pixel counter from i_num_pixels and go to FETCH, or go to LATCH if i_num_pixels is 0.
REQ-019 i_start SHALL be ignored in every state except IDLE.
REQ-020 In FETCH, o_pixel_ready SHALL be 1; on a pixel handshake the block SHALL load the 24-bit shift register and set the bit counter to 23, then go to SHIFT.
REQ-021 The first bit of a pixel SHALL be valid in the cycle after that pixel's handshake.
REQ-022 In SHIFT, o_bit_valid SHALL be 1 and o_bit SHALL equal shift-register bit 23.
REQ-023 In SHIFT, on a bit handshake the shift register SHALL shift left by one and the bit counter SHALL decrement.
REQ-024 o_bit SHALL remain stable while o_bit_valid is high and i_bit_ready is low.
REQ-025 On the handshake of bit counter 0, the pixel counter SHALL decrement; the next state SHALL be LATCH if the remaining count is 0, otherwise FETCH.
REQ-026 o_pixel_ready and o_bit_valid SHALL never be high in the same cycle.
REQ-027 In LATCH, o_latch SHALL be 1 for exactly LATCH_CYCLES cycles.
REQ-028 o_frame_done SHALL pulse in the last LATCH cycle, and the block SHALL be in IDLE the following cycle.
REQ-029 o_underrun SHALL be 1 in FETCH when i_pixel_valid is 0 and at least one pixel of the frame has been sent; it SHALL be 0 for the first pixel.
REQ-030 The pixel counter SHALL be NPIX_W bits wide with no wrap; the maximum frame is 2^NPIX_W-1 pixels.

Reset
REQ-031 While i_reset_n is low at a clock edge, the state SHALL be IDLE and all counters and the shift register SHALL be 0.
REQ-032 During reset, o_pixel_ready, o_bit, o_bit_valid, o_latch, o_busy, o_frame_done and o_underrun SHALL all be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame without an o_frame_done pulse, and the next frame SHALL start cleanly.

Configuration
REQ-034 The macro WS2812_GRB_REORDER_EN, when defined, SHALL treat i_pixel_data as {R,G,B} and load the shift register as {G,R,B}.
REQ-035 When WS2812_GRB_REORDER_EN is undefined, i_pixel_data SHALL be loaded unchanged.

Verification
REQ-036 The bench SHALL cover: num_pixels=1, data 24'hA5C30F, reorder off, i_bit_ready tied high -> o_bit sequence A5C30F MSB first over 24 cycles, then LATCH_CYCLES cycles of o_latch, then one o_frame_done pulse.
REQ-037 The bench SHALL cover: same stimulus with WS2812_GRB_REORDER_EN defined -> bit sequence C3A50F.
REQ-038 The bench SHALL cover: num_pixels=3, i_bit_ready low 2 of every 3 cycles -> o_bit stable while stalled, 72 bits total, no bit lost or duplicated.
REQ-039 The bench SHALL cover: num_pixels=2, i_pixel_valid low for 5 cycles before the second pixel -> o_underrun high for those 5 cycles and never for the first pixel.
REQ-040 The bench SHALL cover: num_pixels=0 -> LATCH entered one cycle after i_start with no pixel handshake, followed by o_frame_done.
REQ-041 The bench SHALL cover: reset asserted at bit 10 of pixel 2 -> all outputs 0 the next cycle, no o_frame_done, and a new frame after reset transmits correctly.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: frame sequencer streaming pixel bits to a WS2812 encoder.
// Build option: define WS2812_GRB_REORDER_EN to send {R,G,B} words as {G,R,B}.
module ws2812_frame_ctrl #(
  parameter int LATCH_CYCLES = 4000,
  parameter int NPIX_W       = 10
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [NPIX_W-1:0] i_num_pixels,
  input  logic [23:0]       i_pixel_data,
  input  logic              i_pixel_valid,
  output logic              o_pixel_ready,
  output logic              o_bit,
  output logic              o_bit_valid,
  input  logic              i_bit_ready,
  output logic              o_latch,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_underrun
);

  localparam int LC_W = $clog2(LATCH_CYCLES);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LATCH_CYCLES - 1);
  localparam logic [NPIX_W-1:0] PIX_ONE = NPIX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LATCH
  } state_e;

  state_e            state_q, state_d;
  logic [NPIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [LC_W-1:0]   latch_cnt_q, latch_cnt_d;
  logic              sent_q, sent_d;
  logic [23:0]       load_word;

  logic in_fetch;
  logic in_shift;
  logic in_latch;

`ifdef WS2812_GRB_REORDER_EN
  assign load_word = {i_pixel_data[15:8],
                      i_pixel_data[23:16],
                      i_pixel_data[7:0]};
`else
  assign load_word = i_pixel_data;
`endif

  // Outputs are gated by reset so they read 0 in any cycle reset is held.
  assign in_fetch = i_reset_n && (state_q == S_FETCH);
  assign in_shift = i_reset_n && (state_q == S_SHIFT);
  assign in_latch = i_reset_n && (state_q == S_LATCH);

  assign o_pixel_ready = in_fetch;
  assign o_bit_valid   = in_shift;
  assign o_bit         = in_shift && shift_q[23];
  assign o_latch       = in_latch;
  assign o_busy        = i_reset_n && (state_q != S_IDLE);
  assign o_frame_done  = in_latch && (latch_cnt_q == '0);
  assign o_underrun    = in_fetch && !i_pixel_valid && sent_q;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    latch_cnt_d = latch_cnt_q;
    sent_d      = sent_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pix_cnt_d   = i_num_pixels;
          sent_d      = 1'b0;
          latch_cnt_d = LC_LAST;
          if (i_num_pixels == '0) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (i_pixel_valid) begin
          shift_d   = load_word;
          bit_cnt_d = 5'd23;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_bit_ready) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_cnt_q == 5'd0) begin
            pix_cnt_d   = pix_cnt_q - PIX_ONE;
            sent_d      = 1'b1;
            latch_cnt_d = LC_LAST;
            if (pix_cnt_q == PIX_ONE) begin
              state_d = S_LATCH;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end
      S_LATCH: begin
        if (latch_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      latch_cnt_q <= '0;
      sent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      latch_cnt_q <= latch_cnt_d;
      sent_q      <= sent_d;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: randomized frames against a bit-queue reference model.
// Reorder expectations follow WS2812_GRB_REORDER_EN when it is defined.
module tb_ws2812_frame_ctrl;

  localparam int LC  = 20;
  localparam int NW  = 10;
  localparam int TMO = 3000;

  logic          clk;
  logic          i_reset_n;
  logic          i_start;
  logic [NW-1:0] i_num_pixels;
  logic [23:0]   i_pixel_data;
  logic          i_pixel_valid;
  logic          o_pixel_ready;
  logic          o_bit;
  logic          o_bit_valid;
  logic          i_bit_ready;
  logic          o_latch;
  logic          o_busy;
  logic          o_frame_done;
  logic          o_underrun;

  ws2812_frame_ctrl #(
    .LATCH_CYCLES(LC),
    .NPIX_W(NW)
  ) dut (
    .i_clk(clk),
    .i_reset_n(i_reset_n),
    .i_start(i_start),
    .i_num_pixels(i_num_pixels),
    .i_pixel_data(i_pixel_data),
    .i_pixel_valid(i_pixel_valid),
    .o_pixel_ready(o_pixel_ready),
    .o_bit(o_bit),
    .o_bit_valid(o_bit_valid),
    .i_bit_ready(i_bit_ready),
    .o_latch(o_latch),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_underrun(o_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;
  int rdy_mode = 0;

  // Observation log, appended on the falling edge only.
  int   cyc = 0;
  logic bit_log[$];
  int   bit_cyc[$];
  int   pix_cyc[$];
  int   pix_n = 0;
  int   latch_n = 0;
  int   done_n = 0;
  int   done_bad = 0;
  int   unr_n = 0;
  int   ovl_n = 0;
  int   stall_err = 0;
  logic stall_q = 1'b0;
  logic bit_q = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_bit_valid && i_bit_ready) begin
      bit_log.push_back(o_bit);
      bit_cyc.push_back(cyc);
    end
    if (o_pixel_ready && i_pixel_valid) begin
      pix_n <= pix_n + 1;
      pix_cyc.push_back(cyc);
    end
    if (o_latch) latch_n <= latch_n + 1;
    if (o_frame_done) begin
      done_n <= done_n + 1;
      if (!o_latch) done_bad <= done_bad + 1;
    end
    if (o_underrun) unr_n <= unr_n + 1;
    if (o_pixel_ready && o_bit_valid) ovl_n <= ovl_n + 1;
    if (stall_q && (!o_bit_valid || o_bit !== bit_q))
      stall_err <= stall_err + 1;
    stall_q <= o_bit_valid && !i_bit_ready && i_reset_n;
    bit_q   <= o_bit;
  end

  // Encoder-side ready pattern: always, 1-in-3, or random.
  initial begin
    int c;
    c = 0;
    i_bit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      if (rdy_mode == 0) i_bit_ready = 1'b1;
      else if (rdy_mode == 1) i_bit_ready = (c % 3 == 0);
      else i_bit_ready = 1'($urandom_range(0, 1));
    end
  end

  int s_bits, s_pix, s_latch, s_done, s_dbad, s_unr, s_ovl, s_stall;

  task automatic snap();
    s_bits  = bit_log.size();
    s_pix   = pix_cyc.size();
    s_latch = latch_n;
    s_done  = done_n;
    s_dbad  = done_bad;
    s_unr   = unr_n;
    s_ovl   = ovl_n;
    s_stall = stall_err;
  endtask

  // Reference model: wire order of a pixel word, then MSB-first bits.
  function automatic logic [23:0] wire_order(input logic [23:0] d);
`ifdef WS2812_GRB_REORDER_EN
    return {d[15:8], d[23:16], d[7:0]};
`else
    return d;
`endif
  endfunction

  logic exp_q[$];

  task automatic build_exp(input logic [23:0] px[$]);
    logic [23:0] w;
    exp_q.delete();
    foreach (px[k]) begin
      w = wire_order(px[k]);
      for (int i = 23; i >= 0; i--) exp_q.push_back(w[i]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    i_reset_n     = 1'b0;
    i_start       = 1'b0;
    i_pixel_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  task automatic start_frame(input int n);
    @(posedge clk);
    #1;
    i_start      = 1'b1;
    i_num_pixels = NW'(n);
    @(posedge clk);
    #1;
    i_start      = 1'b0;
    i_num_pixels = NW'($urandom);
  endtask

  // gap = number of FETCH cycles with valid held low before the word.
  task automatic feed_pixel(input logic [23:0] d, input int gap,
                            output bit to);
    int t;
    to = 1'b0;
    t  = 0;
    i_pixel_data = d;
    if (gap == 0) i_pixel_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!o_pixel_ready && t < TMO);
    if (!o_pixel_ready) begin
      nvec++;
      nerr++;
      $display("FAIL pixel_ready timeout: got 0 want 1");
      i_pixel_valid = 1'b0;
      to = 1'b1;
      return;
    end
    if (gap > 0) begin
      repeat (gap - 1) @(negedge clk);
      @(posedge clk);
      #1;
      i_pixel_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    i_pixel_valid = 1'b0;
    i_pixel_data  = $urandom;
  endtask

  task automatic wait_done(output bit to);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (done_n == s_done && t < TMO);
    to = (done_n == s_done);
    if (to) begin
      nvec++;
      nerr++;
      $display("FAIL frame_done timeout: got 0 pulses want 1");
    end
  endtask

  task automatic run_frame(input int n, input logic [23:0] px[$],
                           input int gp[$], input bit hold_start);
    bit to;
    start_frame(n);
    if (hold_start) i_start = 1'b1;
    to = 1'b0;
    for (int k = 0; k < n && !to; k++) feed_pixel(px[k], gp[k], to);
    i_start = 1'b0;
    if (!to) wait_done(to);
  endtask

  task automatic test_reset();
    i_reset_n     = 1'b0;
    i_start       = 1'b1;
    i_num_pixels  = NW'(5);
    i_pixel_valid = 1'b1;
    i_pixel_data  = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if ({o_pixel_ready, o_bit, o_bit_valid, o_latch, o_busy,
           o_frame_done, o_underrun} !== 7'b0) begin
        nerr++;
        $display("FAIL reset outputs: got %b want 0000000",
                 {o_pixel_ready, o_bit, o_bit_valid, o_latch, o_busy,
                  o_frame_done, o_underrun});
      end
    end
    @(posedge clk);
    #1;
    i_start       = 1'b0;
    i_pixel_valid = 1'b0;
    i_reset_n     = 1'b1;
    @(negedge clk);
    nvec++;
    if (o_busy !== 1'b0 || o_pixel_ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset idle: got busy=%b ready=%b want 0 0",
               o_busy, o_pixel_ready);
    end
  endtask

  task automatic test_single_pixel();
    logic [23:0] px[$];
    int gp[$];
    do_reset();
    rdy_mode = 0;
    snap();
    px = '{24'hA5C30F};
    gp = '{0};
    build_exp(px);
    run_frame(1, px, gp, 1'b0);
    nvec++;
    if (bit_log.size() - s_bits !== 24) begin
      nerr++;
      $display("FAIL single count: got %0d want 24", bit_log.size() - s_bits);
    end
    for (int i = 0; i < 24; i++) begin
      if (s_bits + i < bit_log.size()) begin
        nvec++;
        if (bit_log[s_bits+i] !== exp_q[i]) begin
          nerr++;
          $display("FAIL single bit%0d: got %b want %b",
                   i, bit_log[s_bits+i], exp_q[i]);
        end
      end
    end
    if (bit_log.size() - s_bits >= 24 && pix_cyc.size() > s_pix) begin
      nvec++;
      if (bit_cyc[s_bits] - pix_cyc[s_pix] !== 1) begin
        nerr++;
        $display("FAIL first-bit latency: got %0d want 1",
                 bit_cyc[s_bits] - pix_cyc[s_pix]);
      end
      nvec++;
      if (bit_cyc[s_bits+23] - bit_cyc[s_bits] !== 23) begin
        nerr++;
        $display("FAIL single span: got %0d want 23",
                 bit_cyc[s_bits+23] - bit_cyc[s_bits]);
      end
    end
    nvec++;
    if (latch_n - s_latch !== LC) begin
      nerr++;
      $display("FAIL single latch: got %0d want %0d", latch_n - s_latch, LC);
    end
    nvec++;
    if (done_n - s_done !== 1 || done_bad !== s_dbad) begin
      nerr++;
      $display("FAIL single done: got %0d (outside latch %0d) want 1 (0)",
               done_n - s_done, done_bad - s_dbad);
    end
    @(negedge clk);
    nvec++;
    if (o_busy !== 1'b0) begin
      nerr++;
      $display("FAIL single idle after done: got busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_stall();
    logic [23:0] px[$];
    int gp[$];
    do_reset();
    rdy_mode = 1;
    snap();
    for (int k = 0; k < 3; k++) begin
      px.push_back(24'($urandom));
      gp.push_back(0);
    end
    build_exp(px);
    run_frame(3, px, gp, 1'b0);
    nvec++;
    if (bit_log.size() - s_bits !== 72) begin
      nerr++;
      $display("FAIL stall count: got %0d want 72", bit_log.size() - s_bits);
    end
    for (int i = 0; i < 72; i++) begin
      if (s_bits + i < bit_log.size()) begin
        nvec++;
        if (bit_log[s_bits+i] !== exp_q[i]) begin
          nerr++;
          $display("FAIL stall bit%0d: got %b want %b",
                   i, bit_log[s_bits+i], exp_q[i]);
        end
      end
    end
    nvec++;
    if (stall_err - s_stall !== 0) begin
      nerr++;
      $display("FAIL stall stability: got %0d changes want 0",
               stall_err - s_stall);
    end
    nvec++;
    if (ovl_n - s_ovl !== 0) begin
      nerr++;
      $display("FAIL ready/valid overlap: got %0d want 0", ovl_n - s_ovl);
    end
  endtask

  task automatic test_underrun();
    logic [23:0] px[$];
    int gp[$];
    do_reset();
    rdy_mode = 0;
    snap();
    px = '{24'($urandom), 24'($urandom)};
    gp = '{3, 5};
    build_exp(px);
    run_frame(2, px, gp, 1'b0);
    nvec++;
    if (unr_n - s_unr !== 5) begin
      nerr++;
      $display("FAIL underrun cycles: got %0d want 5", unr_n - s_unr);
    end
    nvec++;
    if (pix_cyc.size() - s_pix !== 2) begin
      nerr++;
      $display("FAIL underrun pixels: got %0d want 2",
               pix_cyc.size() - s_pix);
    end
    for (int i = 0; i < 48; i++) begin
      if (s_bits + i < bit_log.size()) begin
        nvec++;
        if (bit_log[s_bits+i] !== exp_q[i]) begin
          nerr++;
          $display("FAIL underrun bit%0d: got %b want %b",
                   i, bit_log[s_bits+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_pixels();
    bit to;
    do_reset();
    rdy_mode = 0;
    snap();
    start_frame(0);
    @(negedge clk);
    nvec++;
    if (o_latch !== 1'b1 || o_pixel_ready !== 1'b0) begin
      nerr++;
      $display("FAIL zero-pixel latch entry: got latch=%b ready=%b want 1 0",
               o_latch, o_pixel_ready);
    end
    wait_done(to);
    nvec++;
    if (latch_n - s_latch !== LC) begin
      nerr++;
      $display("FAIL zero-pixel latch: got %0d want %0d",
               latch_n - s_latch, LC);
    end
    nvec++;
    if (pix_cyc.size() - s_pix !== 0 || done_n - s_done !== 1) begin
      nerr++;
      $display("FAIL zero-pixel: got pix=%0d done=%0d want 0 1",
               pix_cyc.size() - s_pix, done_n - s_done);
    end
  endtask

  task automatic test_reset_abort();
    logic [23:0] px[$];
    int gp[$];
    bit to;
    int t;
    do_reset();
    rdy_mode = 0;
    snap();
    px = '{24'($urandom), 24'($urandom), 24'($urandom)};
    build_exp(px);
    start_frame(3);
    feed_pixel(px[0], 0, to);
    if (!to) feed_pixel(px[1], 0, to);
    t = 0;
    while (bit_log.size() - s_bits < 34 && t < TMO) begin
      @(posedge clk);
      t++;
    end
    #1;
    i_reset_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({o_pixel_ready, o_bit, o_bit_valid, o_latch, o_busy,
         o_frame_done, o_underrun} !== 7'b0) begin
      nerr++;
      $display("FAIL abort outputs: got %b want 0000000",
               {o_pixel_ready, o_bit, o_bit_valid, o_latch, o_busy,
                o_frame_done, o_underrun});
    end
    for (int i = 0; i < 34; i++) begin
      if (s_bits + i < bit_log.size()) begin
        nvec++;
        if (bit_log[s_bits+i] !== exp_q[i]) begin
          nerr++;
          $display("FAIL abort prefix bit%0d: got %b want %b",
                   i, bit_log[s_bits+i], exp_q[i]);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if (done_n - s_done !== 0 || latch_n - s_latch !== 0) begin
      nerr++;
      $display("FAIL abort done: got done=%0d latch=%0d want 0 0",
               done_n - s_done, latch_n - s_latch);
    end
    rdy_mode = 2;
    snap();
    px = '{24'($urandom), 24'($urandom)};
    gp = '{0, 1};
    build_exp(px);
    run_frame(2, px, gp, 1'b0);
    nvec++;
    if (bit_log.size() - s_bits !== 48 || done_n - s_done !== 1) begin
      nerr++;
      $display("FAIL post-abort frame: got bits=%0d done=%0d want 48 1",
               bit_log.size() - s_bits, done_n - s_done);
    end
    for (int i = 0; i < 48; i++) begin
      if (s_bits + i < bit_log.size()) begin
        nvec++;
        if (bit_log[s_bits+i] !== exp_q[i]) begin
          nerr++;
          $display("FAIL post-abort bit%0d: got %b want %b",
                   i, bit_log[s_bits+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] px[$];
    int gp[$];
    int n;
    int eu;
    for (int f = 0; f < 5; f++) begin
      rdy_mode = 2;
      px.delete();
      gp.delete();
      n  = $urandom_range(1, 4);
      eu = 0;
      for (int k = 0; k < n; k++) begin
        px.push_back(24'($urandom));
        gp.push_back($urandom_range(0, 3));
        if (k > 0) eu += gp[k];
      end
      build_exp(px);
      snap();
      run_frame(n, px, gp, 1'b1);
      nvec++;
      if (bit_log.size() - s_bits !== 24 * n) begin
        nerr++;
        $display("FAIL rand%0d count: got %0d want %0d",
                 f, bit_log.size() - s_bits, 24 * n);
      end
      for (int i = 0; i < 24 * n; i++) begin
        if (s_bits + i < bit_log.size()) begin
          nvec++;
          if (bit_log[s_bits+i] !== exp_q[i]) begin
            nerr++;
            $display("FAIL rand%0d bit%0d: got %b want %b",
                     f, i, bit_log[s_bits+i], exp_q[i]);
          end
        end
      end
      nvec++;
      if (unr_n - s_unr !== eu) begin
        nerr++;
        $display("FAIL rand%0d underrun: got %0d want %0d",
                 f, unr_n - s_unr, eu);
      end
      nvec++;
      if (latch_n - s_latch !== LC || done_n - s_done !== 1) begin
        nerr++;
        $display("FAIL rand%0d latch/done: got %0d/%0d want %0d/1",
                 f, latch_n - s_latch, done_n - s_done, LC);
      end
      nvec++;
      if (stall_err != s_stall || ovl_n != s_ovl || done_bad != s_dbad) begin
        nerr++;
        $display("FAIL rand%0d protocol: got stall=%0d ovl=%0d want 0 0",
                 f, stall_err - s_stall, ovl_n - s_ovl);
      end
      @(negedge clk);
      nvec++;
      if (o_busy !== 1'b0) begin
        nerr++;
        $display("FAIL rand%0d idle: got busy=%b want 0", f, o_busy);
      end
    end
  endtask

  initial begin
    i_reset_n     = 1'b0;
    i_start       = 1'b0;
    i_num_pixels  = '0;
    i_pixel_data  = '0;
    i_pixel_valid = 1'b0;
    test_reset();
    test_single_pixel();
    test_stall();
    test_underrun();
    test_zero_pixels();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
